// File: rtl/simon_pkg.sv
// Shared types for the Simon Says sequencer: FSM states, colour codes and
// the colour-to-lamp decode used by both playback and input checking.
package simon_pkg;

  localparam int unsigned LAMP_W    = 4;
  localparam int unsigned SEQ_DEPTH = 32;
  localparam int unsigned IDX_W     = $clog2(SEQ_DEPTH);
  localparam int unsigned ROUND_W   = $clog2(SEQ_DEPTH + 1);
  localparam int unsigned LFSR_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW_ON,
    SHOW_OFF,
    WAIT_INPUT,
    CHECK,
    WIN,
    LOSE
  } state_t;

  typedef logic [2:0] colour_t;

  localparam colour_t COLOUR_NONE = 3'd0;

  // Codes 1..4 light lamps 0..3; anything else is dark.
  function automatic logic [LAMP_W-1:0] colour_to_lamp(input colour_t c);
    logic [LAMP_W-1:0] lamp;
    case (c)
      3'd1:    lamp = 4'b0001;
      3'd2:    lamp = 4'b0010;
      3'd3:    lamp = 4'b0100;
      3'd4:    lamp = 4'b1000;
      default: lamp = 4'b0000;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11) supplying colour entropy.
// Ports: clk, rst (async active-high), rnd = two low state bits.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] rnd
);

  localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

  logic [LFSR_W-1:0] lfsr_q;

  // Right-shifting Galois form: feedback bit lfsr_q[0] folds into the tap mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon Says game sequencer: grows the colour sequence, plays it back on the
// lamps, then collects and judges player presses.
// Ports: flash_clk/reset (async active-high), start, player_input (one-hot
// buttons); outputs segment (sequence memory), round, disp (lamp drive),
// check_round (player phase), game_over, win. All outputs registered.
module simon_round_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned       MAX_ROUNDS    = 32,
  parameter int unsigned       FLASH_TICKS   = 8,
  parameter int unsigned       GAP_TICKS     = 4,
  parameter int unsigned       INPUT_TIMEOUT = 200,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                       flash_clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LAMP_W-1:0]          player_input,
  output logic [SEQ_DEPTH-1:0][2:0]  segment,
  output logic [ROUND_W-1:0]         round,
  output logic [LAMP_W-1:0]          disp,
  output logic                       check_round,
  output logic                       game_over,
  output logic                       win
);

  localparam int unsigned TICK_MAX = (FLASH_TICKS > GAP_TICKS) ? FLASH_TICKS : GAP_TICKS;
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);
  localparam int unsigned TO_W     = $clog2(INPUT_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [LAMP_W-1:0]   cap_q, cap_d;
  logic                any_q;
  logic [ROUND_W-1:0]  round_d;
  logic                seg_we, seg_clr;
  logic [LAMP_W-1:0]   disp_d;
  logic                check_round_d, game_over_d, win_d;
  logic [1:0]          rnd;
  colour_t             new_colour;
  logic [LAMP_W-1:0]   cur_lamp;
  logic                press;
  logic                more_steps;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (flash_clk),
    .rst (reset),
    .rnd (rnd)
  );

  assign new_colour = colour_t'({1'b0, rnd}) + colour_t'(1);
  assign cur_lamp   = colour_to_lamp(segment[idx_q]);
  // A press is the rising edge of "any button down"; holding never re-triggers.
  assign press      = (player_input != '0) && !any_q;
  assign more_steps = ({1'b0, idx_q} + ROUND_W'(1)) < round;

  // State register.
  always_ff @(posedge flash_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter updates and next output values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    to_d    = to_q;
    cap_d   = cap_q;
    round_d = round;
    seg_we  = 1'b0;
    seg_clr = 1'b0;
    disp_d  = '0;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = GEN;
          seg_clr = 1'b1;
          round_d = '0;
        end
      end
      GEN: begin
        seg_we  = 1'b1;
        round_d = round + ROUND_W'(1);
        idx_d   = '0;
        tick_d  = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        disp_d = cur_lamp;
        if (tick_q == TICK_W'(FLASH_TICKS - 1)) begin
          tick_d  = '0;
          state_d = SHOW_OFF;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      SHOW_OFF: begin
        if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
          tick_d = '0;
          if (more_steps) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SHOW_ON;
          end else begin
            idx_d   = '0;
            to_d    = '0;
            state_d = WAIT_INPUT;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      WAIT_INPUT: begin
        disp_d = player_input;
        if (press) begin
          cap_d   = player_input;
          state_d = CHECK;
        end else if (to_q == TO_W'(INPUT_TIMEOUT - 1)) begin
          state_d = LOSE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      CHECK: begin
        // Simultaneous buttons fail the one-hot test and are judged wrong.
        if (!$onehot(cap_q) || (cap_q != cur_lamp)) begin
          state_d = LOSE;
        end else if (more_steps) begin
          idx_d   = idx_q + IDX_W'(1);
          to_d    = '0;
          state_d = WAIT_INPUT;
        end else if (round == ROUND_W'(MAX_ROUNDS)) begin
          state_d = WIN;
        end else begin
          state_d = GEN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Phase flags follow the next state so they line up with the state itself.
    check_round_d = (state_d == WAIT_INPUT) || (state_d == CHECK);
    game_over_d   = (state_d == WIN) || (state_d == LOSE);
    win_d         = (state_d == WIN);
  end

  // Datapath and output registers.
  always_ff @(posedge flash_clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      tick_q      <= '0;
      to_q        <= '0;
      cap_q       <= '0;
      any_q       <= 1'b0;
      round       <= '0;
      segment     <= '0;
      disp        <= '0;
      check_round <= 1'b0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      to_q        <= to_d;
      cap_q       <= cap_d;
      any_q       <= (player_input != '0);
      round       <= round_d;
      disp        <= disp_d;
      check_round <= check_round_d;
      game_over   <= game_over_d;
      win         <= win_d;
      if (seg_clr) begin
        segment <= '0;
      end else if (seg_we) begin
        segment[round[IDX_W-1:0]] <= new_colour;
      end
    end
  end

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Self-checking bench for simon_round_ctrl: plays games against a
// sequence-level model (expected colour queue derived from the LFSR rule)
// with randomized idle gaps and wrong-button choices.
module tb_simon_round_ctrl;

  localparam int unsigned MAX_R = 4;
  localparam int unsigned FL    = 2;
  localparam int unsigned GP    = 1;
  localparam int unsigned TMO   = 10;

  logic              flash_clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        player_input;
  logic [31:0][2:0]  segment;
  logic [5:0]        round;
  logic [3:0]        disp;
  logic              check_round;
  logic              game_over;
  logic              win;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  q[$];

  simon_round_ctrl #(
    .MAX_ROUNDS    (MAX_R),
    .FLASH_TICKS   (FL),
    .GAP_TICKS     (GP),
    .INPUT_TIMEOUT (TMO),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .flash_clk    (flash_clk),
    .reset        (reset),
    .start        (start),
    .player_input (player_input),
    .segment      (segment),
    .round        (round),
    .disp         (disp),
    .check_round  (check_round),
    .game_over    (game_over),
    .win          (win)
  );

  always #5 flash_clk = ~flash_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Reference generator state: steps once per clock from the seed.
  always @(posedge flash_clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [2:0] colour_of(input logic [15:0] s);
    return 3'(s % 4) + 3'd1;
  endfunction

  function automatic logic [3:0] lamp_of(input logic [2:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return (c >= 3'd1 && c <= 3'd4) ? (one << (c - 3'd1)) : 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge during GEN; verifies new round and full playback.
  task automatic show(input int k);
    @(negedge flash_clk);
    chk("round_after_gen", 32'(round), 32'(k));
    for (int i = 0; i < k; i++) chk("segment_entry", 32'(segment[i]), 32'(q[i]));
    chk("disp_dark_first", 32'(disp), 32'd0);
    chk("phase_off_in_show", 32'(check_round), 32'd0);
    player_input = 4'b0000;
    for (int j = 0; j < k; j++) begin
      repeat (FL) begin
        @(negedge flash_clk);
        chk("disp_lamp", 32'(disp), 32'(lamp_of(q[j])));
      end
      repeat (GP) begin
        @(negedge flash_clk);
        chk("disp_gap", 32'(disp), 32'd0);
      end
    end
    chk("phase_on_after_show", 32'(check_round), 32'd1);
    chk("no_game_over", 32'(game_over), 32'd0);
  endtask

  task automatic start_game();
    repeat ($urandom_range(0, 5)) @(negedge flash_clk);
    start = 1'b1;
    @(negedge flash_clk);
    start = 1'b0;
    q.delete();
    chk("round_cleared", 32'(round), 32'd0);
    chk("segment_cleared", 32'(segment != '0), 32'd0);
    chk("game_over_cleared", 32'(game_over), 32'd0);
    q.push_back(colour_of(m_lfsr));
    show(1);
  endtask

  // Replay round r correctly; optionally hold the first button far longer.
  task automatic play_round(input int r, input bit hold_first);
    logic [3:0] btn;
    for (int j = 0; j < r; j++) begin
      btn = lamp_of(q[j]);
      player_input = btn;
      @(negedge flash_clk);
      chk("echo", 32'(disp), 32'(btn));
      chk("phase_in_check", 32'(check_round), 32'd1);
      if (j < r - 1) begin
        repeat ((hold_first && j == 0) ? 5 : 2) @(negedge flash_clk);
        chk("held_no_repress", 32'(game_over), 32'd0);
        chk("held_phase", 32'(check_round), 32'd1);
        player_input = 4'b0000;
        repeat (2) @(negedge flash_clk);
      end else begin
        @(negedge flash_clk);
        if (r == int'(MAX_R)) begin
          chk("win", 32'(win), 32'd1);
          chk("win_game_over", 32'(game_over), 32'd1);
          chk("win_round", 32'(round), 32'(r));
          player_input = 4'b0000;
        end else begin
          chk("gen_phase_off", 32'(check_round), 32'd0);
          chk("gen_no_game_over", 32'(game_over), 32'd0);
          q.push_back(colour_of(m_lfsr));
          show(r + 1);
        end
      end
    end
  endtask

  task automatic wrong_press(input logic [3:0] btn, input int r);
    player_input = btn;
    @(negedge flash_clk);
    chk("wrong_in_check", 32'(check_round), 32'd1);
    @(negedge flash_clk);
    chk("lose_game_over", 32'(game_over), 32'd1);
    chk("lose_not_win", 32'(win), 32'd0);
    chk("lose_round_held", 32'(round), 32'(r));
    chk("lose_phase_off", 32'(check_round), 32'd0);
    player_input = 4'b0000;
    repeat (2) @(negedge flash_clk);
    chk("lose_seg_held", 32'(segment[0]), 32'(q[0]));
  endtask

  function automatic logic [3:0] wrong_btn(input logic [2:0] c);
    int k;
    k = (int'(c) - 1 + int'($urandom_range(1, 3))) % 4;
    return 4'(1 << k);
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    player_input = 4'b0000;
    repeat (3) @(negedge flash_clk);
    reset = 1'b0;
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_segment", 32'(segment != '0), 32'd0);
    chk("rst_flags", 32'({check_round, game_over, win}), 32'd0);

    // Reset while a lamp is lit.
    start = 1'b1;
    @(negedge flash_clk);
    start = 1'b0;
    q.delete();
    q.push_back(colour_of(m_lfsr));
    repeat (2) @(negedge flash_clk);
    chk("pre_reset_lamp", 32'(disp), 32'(lamp_of(q[0])));
    reset = 1'b1;
    #1;
    chk("async_rst_disp", 32'(disp), 32'd0);
    chk("async_rst_round", 32'(round), 32'd0);
    chk("async_rst_segment", 32'(segment != '0), 32'd0);
    chk("async_rst_flags", 32'({check_round, game_over, win}), 32'd0);
    @(negedge flash_clk);
    reset = 1'b0;
    repeat (3) @(negedge flash_clk);
    chk("idle_stays_round", 32'(round), 32'd0);
    chk("idle_stays_dark", 32'(disp), 32'd0);
    chk("idle_stays_flags", 32'({check_round, game_over}), 32'd0);

    // Full game to a win, with a long-held button in round 2.
    start_game();
    play_round(1, 1'b0);
    play_round(2, 1'b1);
    play_round(3, 1'b0);
    play_round(4, 1'b0);
    repeat (2) @(negedge flash_clk);
    chk("win_held", 32'(win), 32'd1);
    for (int i = 0; i < 4; i++) chk("win_seg_held", 32'(segment[i]), 32'(q[i]));

    // Wrong single button from WIN.
    start_game();
    wrong_press(wrong_btn(q[0]), 1);

    // Two buttons together.
    start_game();
    wrong_press(4'b0011, 1);

    // Timeout with no press.
    start_game();
    repeat (TMO - 1) @(negedge flash_clk);
    chk("tmo_not_yet", 32'(game_over), 32'd0);
    chk("tmo_phase", 32'(check_round), 32'd1);
    @(negedge flash_clk);
    chk("tmo_lose", 32'(game_over), 32'd1);
    chk("tmo_not_win", 32'(win), 32'd0);

    // Randomized games ending on a wrong press at a random round.
    for (int g = 0; g < 4; g++) begin
      start_game();
      n = int'($urandom_range(1, 3));
      for (int r = 1; r < n; r++) play_round(r, 1'($urandom_range(0, 1)));
      wrong_press(wrong_btn(q[0]), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
